// File: rtl/logic_stage_pkg.sv
// Shared definitions for the logic result stage: opcode encodings and the
// per-entry record buffered between the logic unit and the result bus.
package logic_stage_pkg;

   localparam int RES_W = 4;

   localparam logic [2:0] OP_AND     = 3'b000;
   localparam logic [2:0] OP_NAND    = 3'b001;
   localparam logic [2:0] OP_OR      = 3'b010;
   localparam logic [2:0] OP_NOR     = 3'b011;
   localparam logic [2:0] OP_XOR     = 3'b100;
   localparam logic [2:0] OP_XNOR    = 3'b101;
   localparam logic [2:0] OP_NOT     = 3'b110;
   localparam logic [2:0] OP_ILLEGAL = 3'b111;

   typedef struct packed {
      logic [RES_W-1:0] result;
      logic [2:0]       op;
      logic             zero;
      logic             err;
      logic             parity;
   } entry_t;

endpackage

// File: rtl/logic_stage_fifo.sv
// DEPTH-entry synchronous FIFO of entry_t records. Storage is cleared on
// reset; push is ignored when full and pop is ignored when empty.
module logic_stage_fifo
   import logic_stage_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   push,
   input  logic   pop,
   input  entry_t wr_data,
   output entry_t rd_data,
   output logic   full,
   output logic   empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   entry_t             mem_q [DEPTH];
   entry_t             mem_d [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               do_push, do_pop;

   assign full    = (count_q == FULL_CNT);
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem_q[rd_ptr_q];

   // DEPTH is a power of two, so pointer overflow is the modulo wrap.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/logic_result_stage.sv
// Selects one of the seven logic-unit results by opcode, flags zero/illegal,
// and buffers the entry behind a valid/ready FIFO. Optional parity: LOGIC_STAGE_PARITY_EN.
module logic_result_stage
   import logic_stage_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] and_in,
   input  logic [WIDTH-1:0] nand_in,
   input  logic [WIDTH-1:0] or_in,
   input  logic [WIDTH-1:0] nor_in,
   input  logic [WIDTH-1:0] xor_in,
   input  logic [WIDTH-1:0] xnor_in,
   input  logic [WIDTH-1:0] not_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [2:0]       out_op,
   output logic             out_zero,
   output logic             out_err,
   output logic             out_parity
);

   // Handshake: a transfer happens on a rising edge where valid && ready.
   // in_ready depends only on registered fill level, never on out_ready.
   logic             full, empty;
   logic [WIDTH-1:0] sel_result;
   entry_t           new_entry;
   entry_t           head;

   always_comb begin
      sel_result = '0;
      case (op)
         OP_AND:  sel_result = and_in;
         OP_NAND: sel_result = nand_in;
         OP_OR:   sel_result = or_in;
         OP_NOR:  sel_result = nor_in;
         OP_XOR:  sel_result = xor_in;
         OP_XNOR: sel_result = xnor_in;
         OP_NOT:  sel_result = not_in;
         default: sel_result = '0;
      endcase
   end

   always_comb begin
      new_entry        = '0;
      new_entry.result = sel_result;
      new_entry.op     = op;
      new_entry.zero   = (sel_result == '0);
      new_entry.err    = (op == OP_ILLEGAL);
`ifdef LOGIC_STAGE_PARITY_EN
      new_entry.parity = ^sel_result;
`else
      new_entry.parity = 1'b0;
`endif
   end

   logic_stage_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (in_valid),
      .pop     (out_ready),
      .wr_data (new_entry),
      .rd_data (head),
      .full    (full),
      .empty   (empty)
   );

   assign in_ready  = !full;
   assign out_valid = !empty;

   // Head fields are masked while empty so stale slots never reach the bus.
   assign out_result = out_valid ? head.result : '0;
   assign out_op     = out_valid ? head.op     : 3'b000;
   assign out_zero   = out_valid & head.zero;
   assign out_err    = out_valid & head.err;
   assign out_parity = out_valid & head.parity;

endmodule
